// File: rtl/sram_port_arbiter_if.sv
// Bundle of both requesters' read/write handshakes plus the shared SRAM port signals.
// No logic of its own; zero latency.
// No backpressure here: requesters hold req/addr/data until they see their gnt.
interface sram_port_arbiter_if #(
    parameter int AW = 18,
    parameter int DW = 16
);
    logic          rd_req0;
    logic [AW-1:0] rd_addr0;
    logic          rd_gnt0;
    logic          rd_valid0;
    logic [DW-1:0] rd_data0;
    logic          rd_req1;
    logic [AW-1:0] rd_addr1;
    logic          rd_gnt1;
    logic          rd_valid1;
    logic [DW-1:0] rd_data1;

    logic          wr_req0;
    logic [AW-1:0] wr_addr0;
    logic [DW-1:0] wr_data0;
    logic          wr_gnt0;
    logic          wr_req1;
    logic [AW-1:0] wr_addr1;
    logic [DW-1:0] wr_data1;
    logic          wr_gnt1;

    logic [AW-1:0] sram_raddr;
    logic [DW-1:0] sram_rdata;
    logic [AW-1:0] sram_waddr;
    logic [DW-1:0] sram_wdata;
    logic          sram_wr_enable;

    modport slave (
        input  rd_req0, rd_addr0, rd_req1, rd_addr1,
        input  wr_req0, wr_addr0, wr_data0, wr_req1, wr_addr1, wr_data1,
        input  sram_rdata,
        output rd_gnt0, rd_valid0, rd_data0, rd_gnt1, rd_valid1, rd_data1,
        output wr_gnt0, wr_gnt1,
        output sram_raddr, sram_waddr, sram_wdata, sram_wr_enable
    );

    modport master (
        output rd_req0, rd_addr0, rd_req1, rd_addr1,
        output wr_req0, wr_addr0, wr_data0, wr_req1, wr_addr1, wr_data1,
        output sram_rdata,
        input  rd_gnt0, rd_valid0, rd_data0, rd_gnt1, rd_valid1, rd_data1,
        input  wr_gnt0, wr_gnt1,
        input  sram_raddr, sram_waddr, sram_wdata, sram_wr_enable
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin arbiter for the SRAM read port and write port, reads tagged back to the owner.
// Grants are combinational; read data returns RD_LAT cycles after grant, writes complete in the grant cycle.
// A requester holds its request until granted; one read and one write are issued per cycle.
module sram_port_arbiter #(
    parameter int AW     = 18,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_port_arbiter_if.slave   bus
);

    // Bit 0 = grant requester 0, bit 1 = grant requester 1. last = id of the previous winner.
    function automatic logic [1:0] arb(input logic rst, input logic r0, input logic r1,
                                       input logic last);
        logic [1:0] g;
        g = 2'b00;
        if (!rst) begin
            if (r0 && r1) g = last ? 2'b01 : 2'b10;
            else          g = {r1, r0};
        end
        return g;
    endfunction

    logic [1:0]        rd_gnt;
    logic [1:0]        wr_gnt;
    logic              rd_last_q, rd_last_d;
    logic              wr_last_q, wr_last_d;
    logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [RD_LAT-1:0] tag_id_q, tag_id_d;
    logic              out_vld;
    logic              out_id;

    always_comb begin
        rd_gnt    = arb(reset, bus.rd_req0, bus.rd_req1, rd_last_q);
        wr_gnt    = arb(reset, bus.wr_req0, bus.wr_req1, wr_last_q);
        rd_last_d = (|rd_gnt) ? rd_gnt[1] : rd_last_q;
        wr_last_d = (|wr_gnt) ? wr_gnt[1] : wr_last_q;

        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = |rd_gnt;
        tag_id_d[0]  = rd_gnt[1];
        for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_last_q <= 1'b1;
            wr_last_q <= 1'b1;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            rd_last_q <= rd_last_d;
            wr_last_q <= wr_last_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    assign out_vld = tag_vld_q[RD_LAT-1] & ~reset;
    assign out_id  = tag_id_q[RD_LAT-1];

    assign bus.rd_gnt0   = rd_gnt[0];
    assign bus.rd_gnt1   = rd_gnt[1];
    assign bus.rd_valid0 = out_vld & ~out_id;
    assign bus.rd_valid1 = out_vld &  out_id;
    assign bus.rd_data0  = (out_vld & ~out_id) ? bus.sram_rdata : '0;
    assign bus.rd_data1  = (out_vld &  out_id) ? bus.sram_rdata : '0;

    assign bus.sram_raddr = rd_gnt[0] ? bus.rd_addr0 :
                            rd_gnt[1] ? bus.rd_addr1 : '0;

    assign bus.wr_gnt0        = wr_gnt[0];
    assign bus.wr_gnt1        = wr_gnt[1];
    assign bus.sram_wr_enable = |wr_gnt;
    assign bus.sram_waddr     = wr_gnt[0] ? bus.wr_addr0 :
                                wr_gnt[1] ? bus.wr_addr1 : '0;
    assign bus.sram_wdata     = wr_gnt[0] ? bus.wr_data0 :
                                wr_gnt[1] ? bus.wr_data1 : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: one arbiter at RD_LAT=1 and one at RD_LAT=3, each with a behavioural SRAM.
module tb_sram_port_arbiter;

    logic clk;
    logic rst1;
    logic rst3;
    int   n_vec;
    int   n_bad;

    sram_port_arbiter_if #(.AW(18), .DW(16)) bus1 ();
    sram_port_arbiter_if #(.AW(18), .DW(16)) bus3 ();

    sram_port_arbiter #(.AW(18), .DW(16), .RD_LAT(1)) u_dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (bus1.slave)
    );

    sram_port_arbiter #(.AW(18), .DW(16), .RD_LAT(3)) u_dut3 (
        .clk   (clk),
        .reset (rst3),
        .bus   (bus3.slave)
    );

    always #5 clk = ~clk;

    logic [15:0] mem1 [0:(1<<18)-1];
    logic [15:0] mem3 [0:(1<<18)-1];
    logic [15:0] m3_p1, m3_p2;

    always @(posedge clk) begin
        if (bus1.sram_wr_enable) mem1[bus1.sram_waddr] <= bus1.sram_wdata;
        bus1.sram_rdata <= mem1[bus1.sram_raddr];
    end

    always @(posedge clk) begin
        if (bus3.sram_wr_enable) mem3[bus3.sram_waddr] <= bus3.sram_wdata;
        m3_p1           <= mem3[bus3.sram_raddr];
        m3_p2           <= m3_p1;
        bus3.sram_rdata <= m3_p2;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle1();
        bus1.rd_req0 = 0; bus1.rd_addr0 = '0; bus1.rd_req1 = 0; bus1.rd_addr1 = '0;
        bus1.wr_req0 = 0; bus1.wr_addr0 = '0; bus1.wr_data0 = '0;
        bus1.wr_req1 = 0; bus1.wr_addr1 = '0; bus1.wr_data1 = '0;
    endtask

    task automatic idle3();
        bus3.rd_req0 = 0; bus3.rd_addr0 = '0; bus3.rd_req1 = 0; bus3.rd_addr1 = '0;
        bus3.wr_req0 = 0; bus3.wr_addr0 = '0; bus3.wr_data0 = '0;
        bus3.wr_req1 = 0; bus3.wr_addr1 = '0; bus3.wr_data1 = '0;
    endtask

    task automatic pre_wr(input logic [17:0] a, input logic [15:0] d);
        cyc();
        idle1();
        bus1.wr_req0 = 1; bus1.wr_addr0 = a; bus1.wr_data0 = d;
        #1;
        check("pre_wr_gnt0", 32'(bus1.wr_gnt0), 1);
        check("pre_wr_en", 32'(bus1.sram_wr_enable), 1);
        check("pre_waddr", 32'(bus1.sram_waddr), 32'(a));
        check("pre_wdata", 32'(bus1.sram_wdata), 32'(d));
    endtask

    initial begin
        clk = 0; n_vec = 0; n_bad = 0;
        rst1 = 1; rst3 = 1;
        idle1(); idle3();
        bus1.sram_rdata = '0; bus3.sram_rdata = '0;

        // Reset with live requests: nothing may be granted or issued.
        bus1.rd_req0 = 1; bus1.rd_addr0 = 18'h00AAA;
        bus1.rd_req1 = 1; bus1.rd_addr1 = 18'h00BBB;
        bus1.wr_req0 = 1; bus1.wr_addr0 = 18'h00CCC; bus1.wr_data0 = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            check("rst_rd_gnt0", 32'(bus1.rd_gnt0), 0);
            check("rst_rd_gnt1", 32'(bus1.rd_gnt1), 0);
            check("rst_wr_gnt0", 32'(bus1.wr_gnt0), 0);
            check("rst_rd_valid0", 32'(bus1.rd_valid0), 0);
            check("rst_rd_valid1", 32'(bus1.rd_valid1), 0);
            check("rst_wr_en", 32'(bus1.sram_wr_enable), 0);
            check("rst_raddr", 32'(bus1.sram_raddr), 0);
            check("rst_waddr", 32'(bus1.sram_waddr), 0);
        end
        rst1 = 0;
        idle1();

        pre_wr(18'h00010, 16'hBEEF);
        pre_wr(18'h00100, 16'h1111);
        pre_wr(18'h00200, 16'h2222);

        // Single reader
        cyc(); idle1();
        bus1.rd_req0 = 1; bus1.rd_addr0 = 18'h00010;
        #1;
        check("single_gnt0", 32'(bus1.rd_gnt0), 1);
        check("single_gnt1", 32'(bus1.rd_gnt1), 0);
        check("single_raddr", 32'(bus1.sram_raddr), 'h10);
        check("single_early_valid0", 32'(bus1.rd_valid0), 0);
        cyc(); idle1();
        #1;
        check("single_valid0", 32'(bus1.rd_valid0), 1);
        check("single_data0", 32'(bus1.rd_data0), 'hBEEF);
        check("single_valid1", 32'(bus1.rd_valid1), 0);
        check("single_data1", 32'(bus1.rd_data1), 0);
        cyc();
        #1;
        check("single_valid0_pulse", 32'(bus1.rd_valid0), 0);
        check("single_data0_idle", 32'(bus1.rd_data0), 0);

        // Contention from a fresh reset: 0 wins first, then strict alternation.
        cyc(); idle1(); rst1 = 1;
        for (int k = 0; k < 7; k++) begin
            cyc();
            rst1 = 0;
            if (k < 6) begin
                bus1.rd_req0 = 1; bus1.rd_addr0 = 18'h00100;
                bus1.rd_req1 = 1; bus1.rd_addr1 = 18'h00200;
            end else begin
                idle1();
            end
            #1;
            if (k < 6) begin
                check("cont_gnt0", 32'(bus1.rd_gnt0), 32'(k % 2 == 0));
                check("cont_gnt1", 32'(bus1.rd_gnt1), 32'(k % 2 == 1));
                check("cont_raddr", 32'(bus1.sram_raddr), (k % 2 == 0) ? 'h100 : 'h200);
            end
            if (k == 0) begin
                check("cont_first_valid0", 32'(bus1.rd_valid0), 0);
                check("cont_first_valid1", 32'(bus1.rd_valid1), 0);
            end else begin
                check("cont_valid0", 32'(bus1.rd_valid0), 32'((k - 1) % 2 == 0));
                check("cont_valid1", 32'(bus1.rd_valid1), 32'((k - 1) % 2 == 1));
                check("cont_data0", 32'(bus1.rd_data0), ((k - 1) % 2 == 0) ? 'h1111 : 0);
                check("cont_data1", 32'(bus1.rd_data1), ((k - 1) % 2 == 1) ? 'h2222 : 0);
            end
        end

        // Contending writers, including the top address
        cyc(); idle1();
        bus1.wr_req0 = 1; bus1.wr_addr0 = 18'h3FFFF; bus1.wr_data0 = 16'h1234;
        bus1.wr_req1 = 1; bus1.wr_addr1 = 18'h00000; bus1.wr_data1 = 16'hABCD;
        #1;
        check("wr1_gnt0", 32'(bus1.wr_gnt0), 1);
        check("wr1_gnt1", 32'(bus1.wr_gnt1), 0);
        check("wr1_en", 32'(bus1.sram_wr_enable), 1);
        check("wr1_waddr", 32'(bus1.sram_waddr), 'h3FFFF);
        check("wr1_wdata", 32'(bus1.sram_wdata), 'h1234);
        cyc();
        bus1.wr_req0 = 0;
        #1;
        check("wr2_gnt0", 32'(bus1.wr_gnt0), 0);
        check("wr2_gnt1", 32'(bus1.wr_gnt1), 1);
        check("wr2_en", 32'(bus1.sram_wr_enable), 1);
        check("wr2_waddr", 32'(bus1.sram_waddr), 0);
        check("wr2_wdata", 32'(bus1.sram_wdata), 'hABCD);
        cyc(); idle1();
        #1;
        check("wr_idle_en", 32'(bus1.sram_wr_enable), 0);
        check("wr_idle_wdata", 32'(bus1.sram_wdata), 0);

        // Readback of both written locations
        cyc(); idle1();
        bus1.rd_req0 = 1; bus1.rd_addr0 = 18'h3FFFF;
        bus1.rd_req1 = 1; bus1.rd_addr1 = 18'h00000;
        #1;
        check("rb_gnt0", 32'(bus1.rd_gnt0), 1);
        check("rb_raddr0", 32'(bus1.sram_raddr), 'h3FFFF);
        cyc();
        bus1.rd_req0 = 0;
        #1;
        check("rb_gnt1", 32'(bus1.rd_gnt1), 1);
        check("rb_raddr1", 32'(bus1.sram_raddr), 0);
        check("rb_valid0", 32'(bus1.rd_valid0), 1);
        check("rb_data0", 32'(bus1.rd_data0), 'h1234);
        cyc(); idle1();
        #1;
        check("rb_valid1", 32'(bus1.rd_valid1), 1);
        check("rb_data1", 32'(bus1.rd_data1), 'hABCD);

        // Read and write ports serve different requesters in the same cycle
        cyc(); idle1();
        bus1.rd_req0 = 1; bus1.rd_addr0 = 18'h00010;
        bus1.wr_req1 = 1; bus1.wr_addr1 = 18'h00020; bus1.wr_data1 = 16'h5A5A;
        #1;
        check("conc_rd_gnt0", 32'(bus1.rd_gnt0), 1);
        check("conc_wr_gnt1", 32'(bus1.wr_gnt1), 1);
        check("conc_wr_en", 32'(bus1.sram_wr_enable), 1);
        check("conc_raddr", 32'(bus1.sram_raddr), 'h10);
        check("conc_waddr", 32'(bus1.sram_waddr), 'h20);
        cyc(); idle1();
        #1;
        check("conc_valid0", 32'(bus1.rd_valid0), 1);
        check("conc_data0", 32'(bus1.rd_data0), 'hBEEF);

        // RD_LAT=3 instance: latency check, then reset mid-flight
        cyc(); rst3 = 0; idle3();
        bus3.wr_req0 = 1; bus3.wr_addr0 = 18'h00005; bus3.wr_data0 = 16'hCAFE;
        #1;
        check("l3_wr_gnt0", 32'(bus3.wr_gnt0), 1);
        cyc(); idle3();
        bus3.rd_req1 = 1; bus3.rd_addr1 = 18'h00005;
        #1;
        check("l3_rd_gnt1", 32'(bus3.rd_gnt1), 1);
        for (int j = 1; j <= 3; j++) begin
            cyc(); idle3();
            #1;
            check("l3_valid1", 32'(bus3.rd_valid1), 32'(j == 3));
            check("l3_data1", 32'(bus3.rd_data1), (j == 3) ? 'hCAFE : 0);
        end
        cyc(); idle3();
        bus3.rd_req1 = 1; bus3.rd_addr1 = 18'h00005;
        #1;
        check("mf_rd_gnt1", 32'(bus3.rd_gnt1), 1);
        cyc(); idle3(); rst3 = 1;
        #1;
        check("mf_valid1_in_reset", 32'(bus3.rd_valid1), 0);
        check("mf_gnt_in_reset", 32'(bus3.rd_gnt1), 0);
        cyc(); rst3 = 0;
        #1;
        for (int j = 0; j < 5; j++) begin
            cyc();
            #1;
            check("mf_valid1", 32'(bus3.rd_valid1), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the SRAM emulator's single read-only port and single write-only port between two requesters.
- Requester 0 is the decompressor engine. Requester 1 is the frame-fetch path feeding the VGA emulator.
- Each port has an independent round-robin arbiter.
- Read data is returned tagged to the correct requester after a fixed SRAM read latency, so neither client needs to know the other exists.

Parameters:
- AW, 18, SRAM address width
- DW, 16, SRAM data width
- RD_LAT, 1, cycles from sram_raddr presentation to valid sram_rdata (1..4)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- rd_req0  in  1  requester 0 read request, held until granted
- rd_addr0  in  AW  requester 0 read address
- rd_gnt0  out  1  requester 0 read granted this cycle
- rd_valid0  out  1  rd_data0 valid for requester 0
- rd_data0  out  DW  read data to requester 0
- rd_req1, rd_addr1, rd_gnt1, rd_valid1, rd_data1: same as requester 0, for requester 1
- wr_req0  in  1  requester 0 write request
- wr_addr0  in  AW  requester 0 write address
- wr_data0  in  DW  requester 0 write data
- wr_gnt0  out  1  requester 0 write accepted this cycle
- wr_req1, wr_addr1, wr_data1, wr_gnt1: same as requester 0, for requester 1
- sram_raddr  out  AW  SRAM read address
- sram_rdata  in  DW  SRAM read data
- sram_waddr  out  AW  SRAM write address
- sram_wdata  out  DW  SRAM write data
- sram_wr_enable  out  1  SRAM write strobe

Behaviour:

Grants:
- Combinational from the requests and the per-port last-grant register.
- At most one read grant and one write grant per cycle.
- The read and write ports arbitrate independently; the same requester may hold both grants in one cycle.

Round-robin, per port:
- Only one requester active: that requester is granted.
- Both active: grant the requester not named by the last-grant register.
- Last-grant register updates on the clk edge of any granted cycle and holds otherwise.

Read path:
- sram_raddr = address of the granted requester; 0 when nothing is granted.
- Tag pipeline is RD_LAT stages deep, each stage {valid, id}.
- rd_validK pulses exactly RD_LAT cycles after the cycle in which rd_gntK was high.
- rd_dataK = sram_rdata whenever rd_validK = 1; rd_dataK = 0 otherwise.
- Back-to-back grants produce back-to-back valids in grant order.
- Throughput is one read per cycle.

Write path:
- sram_wr_enable = wr_gnt0 | wr_gnt1.
- sram_waddr and sram_wdata are muxed from the granted writer; both are 0 when idle.
- A write is complete in the grant cycle; there is no response.

Request rule:
- A requester keeps req, addr and data stable until it sees its gnt.
- It may drop req, or present a new address, in the cycle after gnt.

Reset (synchronous, every edge with reset = 1):
- All grants, sram_wr_enable and rd_valid are forced to 0 combinationally while reset = 1.
- sram_raddr and sram_waddr are forced to 0.
- Tag pipeline is cleared: no rd_valid is produced for reads granted before reset, including reset asserted mid-flight.
- Both last-grant registers are set to 1, so requester 0 wins the first contention after reset.

Boundary conditions:
- Address wrap: addresses pass through unmodified; 2^AW-1 is legal.
- Simultaneous read and write to the same address: both are issued. Read-before-write ordering is whatever the SRAM emulator provides; the arbiter makes no guarantee.
- A request deasserted before being granted is simply not served.

Size target: 150-250 lines of RTL.

Test Plan:
- Reset: hold reset 3 cycles with rd_req0 = rd_req1 = wr_req0 = 1 -> all gnt, rd_valid and sram_wr_enable = 0; sram_raddr = 0 throughout.
- Single reader: preload mem[0x00010] = 16'hBEEF, rd_req0 = 1 with addr 0x00010 for one cycle -> rd_gnt0 = 1 that cycle; rd_valid0 = 1 with rd_data0 = 16'hBEEF exactly RD_LAT cycles later; rd_valid1 stays 0.
- Contention: both readers request continuously for 6 cycles after reset (addr0 = 0x100, addr1 = 0x200) -> grants alternate 0,1,0,1,0,1; rd_valid0 and rd_valid1 alternate, offset by RD_LAT, with the matching data.
- Writes: wr_req0 (0x3FFFF, 16'h1234) and wr_req1 (0x00000, 16'hABCD) both asserted and held -> cycle 1 writes 0x3FFFF/1234, cycle 2 writes 0x00000/ABCD; readback of both addresses returns those values.
- Mid-flight reset: RD_LAT = 3, grant a read on requester 1, assert reset 1 cycle later -> no rd_valid1 pulse ever appears for that read.
- Concurrent ports: requester 0 reads while requester 1 writes in the same cycle -> rd_gnt0 = 1 and wr_gnt1 = 1 together; neither port stalls.
